draw_board: RTL and testbench

- Pipelined VGA drawing stage that renders the 4x4 memory-card grid over the incoming picture.
- Sits in the 65 MHz pixel chain directly downstream of the start-button rectangle stage and directly upstream of the mouse-cursor overlay.
- Once per frame it also registers the mouse position and reports which card is under the cursor (hover), for the game controller.

---
 rtl/draw_board.sv | 175 +++++++++++++++++
 tb/tb_draw_board.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_board.sv
// Two-stage overlay that draws the 4x4 memory-card grid on the pixel stream and, once per frame,
// reports which card sits under the mouse cursor.
module draw_board #(
  parameter int unsigned X0        = 208,
  parameter int unsigned Y0        = 60,
  parameter int unsigned CARD_W    = 128,
  parameter int unsigned CARD_H    = 144,
  parameter int unsigned GAP       = 24,
  parameter int unsigned BORDER    = 2,
  parameter logic [11:0] BACK_RGB  = 12'h237,
  parameter logic [11:0] FRAME_RGB = 12'hFFF,
  parameter logic [11:0] HOVER_RGB = 12'hFF0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [31:0] card_state,
  input  logic [47:0] card_face,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [3:0]  hover_idx,
  output logic        hover_valid
);

  // Returns {hit, index} of the card span containing p along one axis.
  function automatic logic [2:0] locate(input logic [11:0] p, input int unsigned origin,
                                        input int unsigned size);
    logic [2:0]  r;
    logic [11:0] lo;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      lo = 12'(origin + c * (size + GAP));
      if (p >= lo && p <= lo + 12'(size - 1)) r = {1'b1, 2'(c)};
    end
    return r;
  endfunction

  function automatic logic near_edge(input logic [11:0] p, input int unsigned origin,
                                     input int unsigned size);
    logic        e;
    logic [11:0] lo;
    e = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lo = 12'(origin + c * (size + GAP));
      if (p >= lo && p <= lo + 12'(size - 1))
        e = (p < lo + 12'(BORDER)) || (p > lo + 12'(size - 1 - BORDER));
    end
    return e;
  endfunction

  function automatic logic [11:0] face_rgb(input logic [2:0] f);
    logic [11:0] c;
    unique case (f)
      3'd0: c = 12'hF00;
      3'd1: c = 12'h0F0;
      3'd2: c = 12'h00F;
      3'd3: c = 12'hFF0;
      3'd4: c = 12'hF0F;
      3'd5: c = 12'h0FF;
      3'd6: c = 12'hF80;
      3'd7: c = 12'h888;
    endcase
    return c;
  endfunction

  // Stage-1 registers
  logic [10:0] h_q, v_q;
  logic        hs_q, vs_q, hb_q, vb_q;
  logic [11:0] rgb_q;
  logic [2:0]  col_q, row_q;
  logic        frame_q;

  // Hover tracking state
  logic        vb_prev_q, pend_q;
  logic [11:0] mx_q, my_q;

  logic [2:0]  col_d, row_d, hov_col, hov_row;
  logic        frame_d;
  logic [3:0]  cur_idx;
  logic [1:0]  cur_state;
  logic [2:0]  cur_face;
  logic [11:0] pix;

  always_comb begin
    col_d   = locate({1'b0, hcount_in}, X0, CARD_W);
    row_d   = locate({1'b0, vcount_in}, Y0, CARD_H);
    frame_d = near_edge({1'b0, hcount_in}, X0, CARD_W) ||
              near_edge({1'b0, vcount_in}, Y0, CARD_H);
    hov_col = locate(mx_q, X0, CARD_W);
    hov_row = locate(my_q, Y0, CARD_H);
  end

  always_comb begin
    cur_idx   = {row_q[1:0], col_q[1:0]};
    cur_state = card_state[{cur_idx, 1'b0} +: 2];
    cur_face  = card_face[6'(cur_idx) * 6'd3 +: 3];
    pix       = 12'h000;
    if (hb_q || vb_q)                                  pix = 12'h000;
    else if (!(col_q[2] && row_q[2]) || cur_state == 2'b10) pix = rgb_q;
    else if (frame_q)  pix = (hover_valid && hover_idx == cur_idx) ? HOVER_RGB : FRAME_RGB;
    else if (cur_state == 2'b01)                       pix = face_rgb(cur_face);
    else                                               pix = BACK_RGB;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hb_q        <= 1'b0;
      vb_q        <= 1'b0;
      rgb_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      frame_q     <= 1'b0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      rgb_out     <= '0;
      vb_prev_q   <= 1'b0;
      pend_q      <= 1'b0;
      mx_q        <= '0;
      my_q        <= '0;
      hover_idx   <= '0;
      hover_valid <= 1'b0;
    end else begin
      h_q        <= hcount_in;
      v_q        <= vcount_in;
      hs_q       <= hsync_in;
      vs_q       <= vsync_in;
      hb_q       <= hblnk_in;
      vb_q       <= vblnk_in;
      rgb_q      <= rgb_in;
      col_q      <= col_d;
      row_q      <= row_d;
      frame_q    <= frame_d;
      hcount_out <= h_q;
      vcount_out <= v_q;
      hsync_out  <= hs_q;
      vsync_out  <= vs_q;
      hblnk_out  <= hb_q;
      vblnk_out  <= vb_q;
      rgb_out    <= pix;
      // Latch the mouse on vblank entry, resolve the hovered card one cycle later.
      vb_prev_q  <= vblnk_in;
      pend_q     <= vblnk_in && !vb_prev_q;
      if (vblnk_in && !vb_prev_q) begin
        mx_q <= xpos;
        my_q <= ypos;
      end
      if (pend_q) begin
        hover_valid <= hov_col[2] && hov_row[2];
        hover_idx   <= (hov_col[2] && hov_row[2]) ? {hov_row[1:0], hov_col[1:0]} : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_draw_board.sv
// Randomised and directed bench for draw_board against an arithmetic model of the card grid.
module tb_draw_board;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [31:0] card_state;
  logic [47:0] card_face;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [3:0]  hover_idx;
  logic        hover_valid;

  draw_board dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .card_state(card_state), .card_face(card_face),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .hover_idx(hover_idx), .hover_valid(hover_valid)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF80, 12'h888};

  // Model state: pixel captured one cycle ago, and hover bookkeeping.
  int          s_h, s_v;
  bit          s_hs, s_vs, s_hb, s_vb;
  logic [11:0] s_rgb;
  int          m_x, m_y;
  bit          m_pend, m_pvb, m_val;
  logic [3:0]  m_idx;
  int          e_h, e_v;
  bit          e_hs, e_vs, e_hb, e_vb;
  logic [11:0] e_rgb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit span(input int p, input int org, input int size,
                              output int k, output int off);
    int rel;
    k = 0;
    off = 0;
    if (p < org) return 1'b0;
    rel = p - org;
    k   = rel / (size + 24);
    off = rel % (size + 24);
    return (k < 4) && (off < size);
  endfunction

  function automatic logic [11:0] ref_pix(input int h, input int v, input bit hb, input bit vb,
                                          input logic [11:0] rgb, input logic [31:0] cs,
                                          input logic [47:0] cf, input logic [3:0] hidx,
                                          input bit hval);
    int c, r, ox, oy, idx;
    bit ic, ir;
    logic [1:0] st;
    if (hb || vb) return 12'h000;
    ic = span(h, 208, 128, c, ox);
    ir = span(v, 60, 144, r, oy);
    if (!(ic && ir)) return rgb;
    idx = 4 * r + c;
    st  = cs[2*idx +: 2];
    if (st == 2'b10) return rgb;
    if (ox < 2 || ox > 125 || oy < 2 || oy > 141)
      return (hval && hidx == 4'(idx)) ? 12'hFF0 : 12'hFFF;
    if (st == 2'b01) return pal[cf[3*idx +: 3]];
    return 12'h237;
  endfunction

  task automatic hover_of(input int x, input int y, output logic [3:0] idx, output bit val);
    int c, r, ox, oy;
    bit ic, ir;
    ic  = span(x, 208, 128, c, ox);
    ir  = span(y, 60, 144, r, oy);
    val = (x < 2048) && (y < 2048) && ic && ir;
    idx = val ? 4'(4 * r + c) : 4'd0;
  endtask

  task automatic model_reset();
    s_h = 0; s_v = 0; s_hs = 0; s_vs = 0; s_hb = 0; s_vb = 0; s_rgb = '0;
    m_x = 0; m_y = 0; m_pend = 0; m_pvb = 0; m_val = 0; m_idx = '0;
    e_h = 0; e_v = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0; e_rgb = '0;
  endtask

  task automatic check_outputs();
    chk("rgb_out", rgb_out, e_rgb);
    chk("hcount_out", hcount_out, e_h);
    chk("vcount_out", vcount_out, e_v);
    chk("hsync_out", hsync_out, e_hs);
    chk("vsync_out", vsync_out, e_vs);
    chk("hblnk_out", hblnk_out, e_hb);
    chk("vblnk_out", vblnk_out, e_vb);
    chk("hover_valid", hover_valid, m_val);
    if (m_val) chk("hover_idx", hover_idx, m_idx);
  endtask

  // One clock: advance the model with the currently driven inputs, then compare.
  task automatic step();
    if (rst) begin
      model_reset();
    end else begin
      e_rgb = ref_pix(s_h, s_v, s_hb, s_vb, s_rgb, card_state, card_face, m_idx, m_val);
      e_h = s_h; e_v = s_v; e_hs = s_hs; e_vs = s_vs; e_hb = s_hb; e_vb = s_vb;
      if (m_pend) begin
        hover_of(m_x, m_y, m_idx, m_val);
        m_pend = 0;
      end
      if (vblnk_in && !m_pvb) begin
        m_x = int'(xpos);
        m_y = int'(ypos);
        m_pend = 1;
      end
      m_pvb = vblnk_in;
      s_h = int'(hcount_in); s_v = int'(vcount_in); s_hs = hsync_in; s_vs = vsync_in;
      s_hb = hblnk_in; s_vb = vblnk_in; s_rgb = rgb_in;
    end
    @(posedge pclk);
    #1;
    check_outputs();
  endtask

  task automatic px(input int h, input int v, input bit hb = 0, input bit vb = 0,
                    input logic [11:0] rgb = 12'h0A0);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb; hsync_in = 0; vsync_in = 0; rgb_in = rgb;
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic [11:0] exp);
    px(h, v);
    step();
    step();
    chk(tag, rgb_out, exp);
  endtask

  task automatic vpulse();
    for (int i = 0; i < 4; i++) begin
      px(0, 770, 1, 1);
      step();
    end
    px(0, 0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    px(0, 0, 0, 0, 12'h000);
    xpos = '0; ypos = '0; card_state = '0; card_face = '0;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;

    // Basic grid with all cards hidden
    probe("back_300_100", 300, 100, 12'h237);
    probe("frame_209_61", 209, 61, 12'hFFF);
    probe("gap_340_100", 340, 100, 12'h0A0);
    px(300, 100, 1, 0); step(); step();
    chk("hblank_zero", rgb_out, 12'h000);
    px(300, 100, 0, 1); step(); step();
    chk("vblank_zero", rgb_out, 12'h000);

    // Card 5 revealed with face 3, then matched
    px(0, 0, 1, 0); card_state[11:10] = 2'b01; card_face[17:15] = 3'd3; step();
    probe("face_400_270", 400, 270, 12'hFF0);
    px(0, 0, 1, 0); card_state[11:10] = 2'b10; step();
    probe("matched_pass", 400, 270, 12'h0A0);
    px(0, 0, 1, 0); card_state[11:10] = 2'b00; step();

    // Hover tracking
    xpos = 12'd370; ypos = 12'd230;
    for (int i = 0; i < 5; i++) begin px(300 + i, 100); step(); end
    chk("hover_hold", hover_valid, 1'b0);
    vpulse();
    chk("hover_valid5", hover_valid, 1'b1);
    chk("hover_idx5", hover_idx, 4'd5);
    probe("hover_frame", 360, 300, 12'hFF0);
    probe("hover_frame_b", 400, 371, 12'hFF0);
    probe("hover_inner", 400, 300, 12'h237);
    xpos = 12'd350;
    vpulse();
    chk("hover_gap", hover_valid, 1'b0);

    // Last column and row edges
    probe("edge_h791", 791, 100, 12'hFFF);
    probe("edge_h792", 792, 100, 12'h0A0);
    probe("edge_v707", 300, 707, 12'hFFF);
    probe("edge_v708", 300, 708, 12'h0A0);

    // Timing alignment
    px(1048, 100, 1, 0); hsync_in = 1'b1; step();
    px(1049, 100, 1, 0); step();
    chk("hsync_align", hsync_out, 1'b1);
    chk("hcount_align", hcount_out, 11'd1048);

    // Randomised traffic with a mid-line asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #3 rst = 1'b1;
        #1;
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_hcount", hcount_out, 11'd0);
        chk("rst_hover", hover_valid, 1'b0);
        step();
        rst = 1'b0;
        probe("post_rst", 300, 100, 12'h237 ^ (card_state[1:0] == 2'b01 ?
              (12'h237 ^ pal[card_face[2:0]]) : (card_state[1:0] == 2'b10 ? 12'h297 : 12'h000)));
      end
      if ($urandom_range(0, 49) == 0) vblnk_in = ~vblnk_in;
      hblnk_in  = ($urandom_range(0, 7) == 0);
      hcount_in = 11'($urandom_range(0, 1343));
      vcount_in = 11'($urandom_range(0, 805));
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
      rgb_in    = 12'($urandom);
      if ((hblnk_in || vblnk_in) && $urandom_range(0, 9) == 0) begin
        card_state = $urandom;
        card_face  = {16'($urandom), 32'($urandom)};
      end
      if ($urandom_range(0, 29) == 0) begin
        xpos = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 900));
        ypos = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 800));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
